tile_renderer: RTL and testbench

- Parametrised, pipelined successor to the combinational tile colour generator.
- Converts the VGA pixel counters into a registered 12-bit RGB stream for a tile grid with N sprite channels (Bullet Bills), a homeworld column, the Blockieee player and an enemy (DDaver) grid read from external RAM.
- Sprite and player state is double-buffered and swapped at frame start, so mid-frame game updates never tear.
- Sits between the VGA timing generator and the VGA output pins.

---
 rtl/tile_renderer.sv | 196 +++++++++++++++++++
 tb/tb_tile_renderer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_renderer.sv
// Pipelined tile-grid colour generator: VGA counters in, registered 12-bit RGB out two cycles later.
// Optional grid-line overlay is enabled by defining TILE_RENDERER_GRID_LINES_EN.
module tile_renderer #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned TILE_SIZE       = 40,
    parameter int unsigned COLS            = 16,
    parameter int unsigned ROWS            = 12,
    parameter int unsigned NUM_SPRITES     = 3,
    parameter int unsigned ENEMY_ROWS      = 5,
    parameter int unsigned ENEMY_COLS      = 6,
    parameter int unsigned ENEMY_COL_START = 4,
    parameter logic [11:0] HOME_COLOR      = 12'h282,
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
    localparam int unsigned EA_W  = (ENEMY_ROWS * ENEMY_COLS > 1) ? $clog2(ENEMY_ROWS * ENEMY_COLS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic [9:0]       hcount,
    input  logic [9:0]       vcount,
    input  logic [ROW_W-1:0] player_row,
    input  logic             spr_wr_valid,
    output logic             spr_wr_ready,
    input  logic [IDX_W-1:0] spr_wr_idx,
    input  logic [COL_W-1:0] spr_wr_col,
    input  logic [ROW_W-1:0] spr_wr_row,
    input  logic [11:0]      spr_wr_color,
    output logic [EA_W-1:0]  enemy_rd_addr,
    input  logic [11:0]      enemy_rd_data,
    output logic [11:0]      rgb,
    output logic             rgb_valid
);
    localparam int unsigned SUB_W = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
    // Tile counters saturate one past the grid so blanking never wraps back into it.
    localparam int unsigned CC_W  = $clog2(COLS + 1);
    localparam int unsigned RC_W  = $clog2(ROWS + 1);

    typedef struct packed {
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        logic [11:0]      color;
    } spr_t;

    typedef enum logic {WAIT_SYNC, RUN} state_t;

    state_t           state_q, state_d;
    logic             ready_q;
    spr_t             shadow_q [NUM_SPRITES];
    spr_t             active_q [NUM_SPRITES];
    logic [ROW_W-1:0] prow_q;

    logic [SUB_W-1:0] xsub_q, ysub_q;
    logic [CC_W-1:0]  col_q;
    logic [RC_W-1:0]  row_q;

    logic             line_start, frame_start, wr_fire, pix_active;
    logic [SUB_W-1:0] cur_xsub, cur_ysub, nxt_xsub;
    logic [CC_W-1:0]  cur_col, nxt_col;
    logic [RC_W-1:0]  cur_row;

    logic             s1_valid, s1_active;
    logic [CC_W-1:0]  s1_col;
    logic [RC_W-1:0]  s1_row;
`ifdef TILE_RENDERER_GRID_LINES_EN
    logic             s1_edge;
`endif

    logic             spr_hit, enemy_slot;
    logic [11:0]      spr_color, color_d;

    assign line_start   = (hcount == 10'd0);
    assign frame_start  = pix_en && line_start && (vcount == 10'd0);
    assign spr_wr_ready = ready_q && !frame_start;
    assign wr_fire      = spr_wr_valid && spr_wr_ready;

    // Frame sync FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_SYNC: if (frame_start) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = WAIT_SYNC;
        endcase
    end

    // Divider-free tile position of the pixel presented this cycle
    always_comb begin
        cur_xsub = line_start ? '0 : xsub_q;
        cur_col  = line_start ? '0 : col_q;
        cur_ysub = ysub_q;
        cur_row  = row_q;
        if (line_start) begin
            if (vcount == 10'd0) begin
                cur_ysub = '0;
                cur_row  = '0;
            end else if (ysub_q == SUB_W'(TILE_SIZE - 1)) begin
                cur_ysub = '0;
                cur_row  = (row_q < RC_W'(ROWS)) ? row_q + RC_W'(1) : row_q;
            end else begin
                cur_ysub = ysub_q + SUB_W'(1);
            end
        end
        nxt_xsub = cur_xsub + SUB_W'(1);
        nxt_col  = cur_col;
        if (cur_xsub == SUB_W'(TILE_SIZE - 1)) begin
            nxt_xsub = '0;
            nxt_col  = (cur_col < CC_W'(COLS)) ? cur_col + CC_W'(1) : cur_col;
        end
        pix_active = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE)) &&
                     (cur_col < CC_W'(COLS)) && (cur_row < RC_W'(ROWS));
        enemy_rd_addr = reset ? '0 :
            EA_W'(32'(cur_row >> 1) * ENEMY_COLS + 32'(cur_col >> 1) - ENEMY_COL_START / 2);
    end

    // Stage 1 priority resolve; sprites scanned high to low so the lowest index wins
    always_comb begin
        spr_hit   = 1'b0;
        spr_color = '0;
        for (int i = int'(NUM_SPRITES) - 1; i >= 0; i--) begin
            if (active_q[i].color != 12'h000 && CC_W'(active_q[i].col) == s1_col &&
                RC_W'(active_q[i].row) == s1_row) begin
                spr_hit   = 1'b1;
                spr_color = active_q[i].color;
            end
        end
        enemy_slot = s1_row[0] && !s1_col[0] && (s1_col >= CC_W'(ENEMY_COL_START)) &&
                     ((32'(s1_col - CC_W'(ENEMY_COL_START)) >> 1) < ENEMY_COLS) &&
                     ((32'(s1_row) >> 1) < ENEMY_ROWS);
        color_d = '0;
        if (s1_active) begin
            if (s1_col == '0)                                         color_d = HOME_COLOR;
            else if (s1_col == CC_W'(1) && s1_row == RC_W'(prow_q))   color_d = 12'hFFF;
            else if (spr_hit)                                         color_d = spr_color;
            else if (enemy_slot)                                      color_d = enemy_rd_data;
`ifdef TILE_RENDERER_GRID_LINES_EN
            else if (s1_edge)                                         color_d = 12'h222;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= WAIT_SYNC;
            ready_q   <= 1'b0;
            prow_q    <= '0;
            xsub_q    <= '0;
            ysub_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            s1_valid  <= 1'b0;
            s1_active <= 1'b0;
            s1_col    <= '0;
            s1_row    <= '0;
`ifdef TILE_RENDERER_GRID_LINES_EN
            s1_edge   <= 1'b0;
`endif
            rgb       <= '0;
            rgb_valid <= 1'b0;
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            if (frame_start) begin
                prow_q <= player_row;
                for (int i = 0; i < int'(NUM_SPRITES); i++) active_q[i] <= shadow_q[i];
            end
            // Out-of-range indices match no entry and are dropped
            for (int i = 0; i < int'(NUM_SPRITES); i++) begin
                if (wr_fire && spr_wr_idx == IDX_W'(i))
                    shadow_q[i] <= {spr_wr_col, spr_wr_row, spr_wr_color};
            end
            if (pix_en) begin
                xsub_q    <= nxt_xsub;
                col_q     <= nxt_col;
                ysub_q    <= cur_ysub;
                row_q     <= cur_row;
                s1_active <= pix_active;
                s1_col    <= cur_col;
                s1_row    <= cur_row;
`ifdef TILE_RENDERER_GRID_LINES_EN
                s1_edge   <= (cur_xsub == '0) || (cur_ysub == '0);
`endif
            end
            s1_valid  <= pix_en && (state_q == RUN || frame_start);
            rgb_valid <= s1_valid;
            if (s1_valid) rgb <= color_d;
        end
    end

endmodule

// File: tb/tb_tile_renderer.sv
// Directed self-checking bench for tile_renderer; enemy RAM model returns address+1.
module tb_tile_renderer;
    logic        clk = 1'b0;
    logic        reset, pix_en;
    logic [9:0]  hcount, vcount;
    logic [3:0]  player_row;
    logic        spr_wr_valid, spr_wr_ready;
    logic [1:0]  spr_wr_idx;
    logic [3:0]  spr_wr_col, spr_wr_row;
    logic [11:0] spr_wr_color;
    logic [4:0]  enemy_rd_addr;
    logic [11:0] enemy_rd_data = 12'h000;
    logic [11:0] rgb;
    logic        rgb_valid;

    int total = 0;
    int bad   = 0;
    logic seen;

    tile_renderer dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
        .player_row(player_row), .spr_wr_valid(spr_wr_valid), .spr_wr_ready(spr_wr_ready),
        .spr_wr_idx(spr_wr_idx), .spr_wr_col(spr_wr_col), .spr_wr_row(spr_wr_row),
        .spr_wr_color(spr_wr_color), .enemy_rd_addr(enemy_rd_addr),
        .enemy_rd_data(enemy_rd_data), .rgb(rgb), .rgb_valid(rgb_valid)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model
    always @(posedge clk) enemy_rd_data <= 12'(enemy_rd_addr) + 12'd1;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int h, input int v);
        @(negedge clk);
        pix_en = 1'b1;
        hcount = 10'(h);
        vcount = 10'(v);
    endtask

    task automatic lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) drive(0, v);
    endtask

    task automatic span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) drive(h, v);
    endtask

    // One idle cycle, then stop at the negedge where the last pixel's rgb is visible
    task automatic settle();
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic spr_write(input int idx, input int col, input int row, input logic [11:0] color);
        @(negedge clk);
        pix_en       = 1'b0;
        spr_wr_valid = 1'b1;
        spr_wr_idx   = 2'(idx);
        spr_wr_col   = 4'(col);
        spr_wr_row   = 4'(row);
        spr_wr_color = color;
        @(negedge clk);
        spr_wr_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; hcount = '0; vcount = '0; player_row = 4'd3;
        spr_wr_valid = 1'b0; spr_wr_idx = '0; spr_wr_col = '0; spr_wr_row = '0; spr_wr_color = '0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_valid", 32'(rgb_valid), 32'h0);
        chk("rst_ready", 32'(spr_wr_ready), 32'h0);
        chk("rst_addr", 32'(enemy_rd_addr), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(spr_wr_ready), 32'h1);

        // No frame start yet: output must stay invalid
        seen = 1'b0;
        for (int h = 0; h <= 20; h++) begin
            drive(h, 5);
            seen = seen | rgb_valid;
        end
        settle();
        seen = seen | rgb_valid;
        chk("nosync_valid", 32'(seen), 32'h0);

        // Frame 1
        drive(0, 0);
        settle();
        chk("f1_valid", 32'(rgb_valid), 32'h1);
        chk("f1_origin", 32'(rgb), 32'h282);
        lines(1, 49);
        span(50, 0, 169);
        drive(170, 50); #1;
        chk("addr_170_50", 32'(enemy_rd_addr), 32'd0);
        settle();
        chk("enemy_170_50", 32'(rgb), 32'h001);
        span(50, 171, 569);
        drive(570, 50); #1;
        chk("addr_570_50", 32'(enemy_rd_addr), 32'd5);
        settle();
        chk("enemy_570_50", 32'(rgb), 32'h006);
        span(50, 571, 610);
        settle();
        chk("odd_col_610_50", 32'(rgb), 32'h0);
        spr_write(0, 5, 2, 12'hF00);
        spr_write(1, 5, 2, 12'h0F0);
        spr_write(2, 15, 11, 12'h00F);
        lines(51, 89);
        span(90, 0, 210);
        settle();
        chk("spr_before_swap", 32'(rgb), 32'h0);
        lines(91, 99);
        span(100, 0, 20);
        settle();
        chk("home_20_100", 32'(rgb), 32'h282);
        lines(101, 129);
        span(130, 0, 60);
        settle();
        chk("player_60_130", 32'(rgb), 32'hFFF);
        lines(131, 169);
        span(170, 0, 60);
        settle();
        chk("col1_other_row", 32'(rgb), 32'h0);
        lines(171, 369);
        span(370, 0, 409);
        drive(410, 370); #1;
        chk("addr_410_370", 32'(enemy_rd_addr), 32'd27);
        settle();
        chk("enemy_410_370", 32'(rgb), 32'h01C);
        lines(371, 449);
        span(450, 0, 170);
        settle();
        chk("enemy_row_out", 32'(rgb), 32'h0);

        // Frame 2: swapped sprites, lower index wins
        drive(0, 0);
        settle();
        lines(1, 89);
        span(90, 0, 210);
        settle();
        chk("spr0_wins", 32'(rgb), 32'hF00);
        spr_write(0, 5, 2, 12'h000);
        spr_write(3, 5, 2, 12'hABC);
        lines(91, 478);
        span(479, 0, 639);
        settle();
        chk("corner_valid", 32'(rgb_valid), 32'h1);
        chk("corner_spr", 32'(rgb), 32'h00F);
        span(479, 640, 640);
        settle();
        chk("beyond_h", 32'(rgb), 32'h0);

        // Frame 3: write held across the frame start
        @(negedge clk);
        pix_en = 1'b1; hcount = 10'd0; vcount = 10'd0;
        spr_wr_valid = 1'b1; spr_wr_idx = 2'd2; spr_wr_col = 4'd5; spr_wr_row = 4'd2;
        spr_wr_color = 12'h00F;
        #1;
        chk("ready_at_fs", 32'(spr_wr_ready), 32'h0);
        @(negedge clk);
        hcount = 10'd1;
        #1;
        chk("ready_after_fs", 32'(spr_wr_ready), 32'h1);
        @(negedge clk);
        spr_wr_valid = 1'b0;
        pix_en = 1'b0;
        lines(1, 89);
        span(90, 0, 210);
        settle();
        chk("spr1_after_disable", 32'(rgb), 32'h0F0);
        spr_write(1, 5, 2, 12'h000);

        // Frame 4: held write landed
        drive(0, 0);
        settle();
        lines(1, 89);
        span(90, 0, 210);
        settle();
        chk("held_write", 32'(rgb), 32'h00F);
        lines(91, 199);
        span(200, 0, 20);
        @(negedge clk);
        reset = 1'b1; hcount = 10'd21;
        @(negedge clk);
        chk("mid_rst_rgb", 32'(rgb), 32'h0);
        chk("mid_rst_valid", 32'(rgb_valid), 32'h0);
        hcount = 10'd22;
        @(negedge clk);
        reset = 1'b0; hcount = 10'd23;
        seen = 1'b0;
        for (int h = 24; h <= 100; h++) begin
            drive(h, 200);
            seen = seen | rgb_valid;
        end
        for (int v = 201; v <= 210; v++) begin
            drive(0, v);
            seen = seen | rgb_valid;
        end
        settle();
        seen = seen | rgb_valid;
        chk("rst_no_partial", 32'(seen), 32'h0);

        // Frame 5: resync, grid lines, cleared sprites
        drive(0, 0);
        settle();
        chk("resync_valid", 32'(rgb_valid), 32'h1);
        chk("resync_rgb", 32'(rgb), 32'h282);
        lines(1, 9);
        span(10, 0, 80);
        settle();
`ifdef TILE_RENDERER_GRID_LINES_EN
        chk("grid_80_10", 32'(rgb), 32'h222);
`else
        chk("grid_80_10", 32'(rgb), 32'h0);
`endif
        span(11, 0, 81);
        settle();
        chk("grid_81_11", 32'(rgb), 32'h0);
        lines(12, 89);
        span(90, 0, 210);
        settle();
        chk("spr_cleared", 32'(rgb), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
